// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG DC scheduling path.
package jpeg_pkg;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_e;

    typedef enum logic [1:0] {
        SLOT_Y  = 2'd0,
        SLOT_CB = 2'd1,
        SLOT_CR = 2'd2
    } slot_e;

    localparam int DC_W         = 10;
    localparam int ENC_RES_W    = 32;
    localparam int RES_CODE_LSB = 24;
    localparam int RES_LEN_LSB  = 16;
    localparam int RES_BITS_LSB = 8;
    localparam int RES_SIZE_LSB = 0;
    localparam int DC_DIFF_MAX  = 255;
    localparam int ENC_LATENCY  = 2;
    // One local register stage ahead of the encoder's own pipeline.
    localparam int TAG_STAGES   = ENC_LATENCY + 1;

    typedef struct packed {
        logic  vld;
        comp_e comp;
        logic  restart;
    } tag_t;

    typedef struct packed {
        logic                 restart;
        comp_e                comp;
        logic [ENC_RES_W-1:0] code;
    } outq_entry_t;

endpackage

// File: rtl/jpeg_dc_outq.sv
// Synchronous FIFO with occupancy count; write and read may coincide when full.
module jpeg_dc_outq #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_rd;

    assign do_rd = rd_en_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Upstream credit accounting must make an overflowing write impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(wr_en_i && (count_q == CW'(DEPTH)) && !do_rd));
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;

endmodule

// File: rtl/jpeg_dc_scheduler.sv
// DC predictor / table-select front end for the 2-stage Huffman DC encoder with a credit-protected result queue.
// Optional restart-interval handling is compiled in with `define DC_RESTART_EN.
module jpeg_dc_scheduler
    import jpeg_pkg::*;
#(
    parameter int LUMA_PER_MCU     = 4,
    parameter int FIFO_DEPTH       = 4,
    parameter int RESTART_INTERVAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DC_W-1:0] in_dc,
    output logic signed [DC_W-1:0] enc_dc,
    output logic                   enc_is_luminance,
    input  logic [ENC_RES_W-1:0]   enc_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ENC_RES_W-1:0]   out_code,
    output logic [1:0]             out_comp,
    output logic                   out_restart
);
    localparam int QCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FLT_W  = $clog2(TAG_STAGES + 1);
    localparam logic signed [DC_W:0] SAT_HI = (DC_W+1)'(DC_DIFF_MAX);
    localparam logic signed [DC_W:0] SAT_LO = -SAT_HI;

    if (!(LUMA_PER_MCU == 1 || LUMA_PER_MCU == 2 || LUMA_PER_MCU == 4) || (FIFO_DEPTH < 4) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (RESTART_INTERVAL < 0)) begin : g_bad_params
        $error("jpeg_dc_scheduler: unsupported parameter set");
    end

    function automatic logic signed [DC_W-1:0] sat_diff(input logic signed [DC_W-1:0] dc,
                                                        input logic signed [DC_W-1:0] pred);
        logic signed [DC_W:0] d;
        d = (DC_W+1)'(dc) - (DC_W+1)'(pred);
        if (d > SAT_HI)      return DC_W'(SAT_HI);
        else if (d < SAT_LO) return DC_W'(SAT_LO);
        else                 return DC_W'(d);
    endfunction

    slot_e                  slot_q, slot_d;
    logic [2:0]             luma_idx_q, luma_idx_d;
    comp_e                  comp;
    logic                   accept;
    logic                   boundary;
    logic                   tag_restart;
    logic signed [DC_W-1:0] pred_y_q, pred_cb_q, pred_cr_q, pred_sel;
    logic signed [DC_W-1:0] enc_dc_q;
    logic                   enc_lum_q;
    tag_t                   tag_q [TAG_STAGES];
    logic [FLT_W-1:0]       inflight;
    logic [QCNT_W-1:0]      q_count;
    outq_entry_t            wr_entry, rd_entry;

    // Credits: a block is admitted only if its result is guaranteed a queue slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < TAG_STAGES; i++) inflight = inflight + FLT_W'(tag_q[i].vld);
    end

    assign in_ready = (32'(q_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= SLOT_Y;
            luma_idx_q <= '0;
        end else begin
            slot_q     <= slot_d;
            luma_idx_q <= luma_idx_d;
        end
    end

    always_comb begin
        slot_d     = slot_q;
        luma_idx_d = luma_idx_q;
        comp       = COMP_Y;
        case (slot_q)
            SLOT_Y: begin
                if (accept) begin
                    if (luma_idx_q == 3'(LUMA_PER_MCU - 1)) begin
                        luma_idx_d = '0;
                        slot_d     = SLOT_CB;
                    end else begin
                        luma_idx_d = luma_idx_q + 3'd1;
                    end
                end
            end
            SLOT_CB: begin
                comp = COMP_CB;
                if (accept) slot_d = SLOT_CR;
            end
            SLOT_CR: begin
                comp = COMP_CR;
                if (accept) slot_d = SLOT_Y;
            end
            default: slot_d = SLOT_Y;
        endcase
    end

`ifdef DC_RESTART_EN
    logic [31:0] mcu_cnt_q, mcu_cnt_d;
    logic        pend_q, pend_d;

    always_comb begin
        mcu_cnt_d = mcu_cnt_q;
        pend_d    = pend_q;
        boundary  = 1'b0;
        if (accept) begin
            pend_d = 1'b0;
            if ((RESTART_INTERVAL > 0) && (slot_q == SLOT_CR)) begin
                if (mcu_cnt_q == 32'(RESTART_INTERVAL - 1)) begin
                    mcu_cnt_d = '0;
                    pend_d    = 1'b1;
                    boundary  = 1'b1;
                end else begin
                    mcu_cnt_d = mcu_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcu_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            mcu_cnt_q <= mcu_cnt_d;
            pend_q    <= pend_d;
        end
    end

    assign tag_restart = pend_q;
`else
    assign boundary    = 1'b0;
    assign tag_restart = 1'b0;
`endif

    always_comb begin
        case (comp)
            COMP_CB: pred_sel = pred_cb_q;
            COMP_CR: pred_sel = pred_cr_q;
            default: pred_sel = pred_y_q;
        endcase
    end

    // A restart boundary wins over the triggering CR block's predictor update.
    always_ff @(posedge clk) begin
        if (rst || boundary) begin
            pred_y_q  <= '0;
            pred_cb_q <= '0;
            pred_cr_q <= '0;
        end else if (accept) begin
            case (comp)
                COMP_CB: pred_cb_q <= in_dc;
                COMP_CR: pred_cr_q <= in_dc;
                default: pred_y_q  <= in_dc;
            endcase
        end
    end

    // Stage p0: difference and table select registered toward the encoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_dc_q  <= '0;
            enc_lum_q <= 1'b0;
        end else if (accept) begin
            enc_dc_q  <= sat_diff(in_dc, pred_sel);
            enc_lum_q <= (comp == COMP_Y);
        end
    end

    assign enc_dc           = enc_dc_q;
    assign enc_is_luminance = enc_lum_q;

    // Tag pipe mirrors the encoder latency so each result meets its own tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAG_STAGES; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{vld: accept, comp: comp, restart: tag_restart};
            for (int i = 1; i < TAG_STAGES; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign wr_entry = '{restart: tag_q[TAG_STAGES-1].restart,
                        comp:    tag_q[TAG_STAGES-1].comp,
                        code:    enc_result};

    jpeg_dc_outq #(
        .WIDTH($bits(outq_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_outq (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (tag_q[TAG_STAGES-1].vld),
        .wr_data_i(wr_entry),
        .rd_en_i  (out_ready),
        .rd_data_o(rd_entry),
        .valid_o  (out_valid),
        .count_o  (q_count)
    );

    assign out_code    = rd_entry.code;
    assign out_comp    = rd_entry.comp;
    assign out_restart = rd_entry.restart;

endmodule

// File: tb/tb_jpeg_dc_scheduler.sv
// Scoreboard bench for jpeg_dc_scheduler with a behavioural 2-stage encoder.
module tb_jpeg_dc_scheduler;

`ifdef DC_RESTART_EN
    localparam int LUMA   = 1;
    localparam int RI     = 1;
    localparam bit RST_EN = 1'b1;
`else
    localparam int LUMA   = 4;
    localparam int RI     = 0;
    localparam bit RST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] code;
        logic [1:0]  comp;
        logic        restart;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [9:0] in_dc;
    logic signed [9:0] enc_dc;
    logic              enc_is_luminance;
    logic [31:0]       enc_result;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_code;
    logic [1:0]        out_comp;
    logic              out_restart;

    logic [31:0] enc_s1, enc_s2;
    exp_t        exp_q[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          ov_cyc = 0;
    bit          lat_arm = 1'b0;
    bit          rand_rdy = 1'b0;
    int          mp[3];
    int          mli, mslot, mcnt;
    bit          mpend;

    jpeg_dc_scheduler #(
        .LUMA_PER_MCU    (LUMA),
        .FIFO_DEPTH      (4),
        .RESTART_INTERVAL(RI)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_dc           (in_dc),
        .enc_dc          (enc_dc),
        .enc_is_luminance(enc_is_luminance),
        .enc_result      (enc_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_code        (out_code),
        .out_comp        (out_comp),
        .out_restart     (out_restart)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] enc_code(input logic [9:0] d, input logic lum);
        return {7'h50, lum, 14'd0, d};
    endfunction

    // Stand-in encoder: two register stages, result is a tagged copy of its inputs.
    always @(posedge clk) begin
        enc_s1 <= enc_code(enc_dc, enc_is_luminance);
        enc_s2 <= enc_s1;
    end
    assign enc_result = enc_s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (lat_arm && out_valid) begin
            ov_cyc  = cyc;
            lat_arm = 1'b0;
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got code %0h with nothing expected", out_code);
            end else begin
                e = exp_q.pop_front();
                chk("out_code", out_code, e.code);
                chk("out_comp", 32'(out_comp), 32'(e.comp));
                chk("out_restart", 32'(out_restart), 32'(e.restart));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int dc, input int ed, input int ec, input int er, input bit push);
        int  n;
        bit  done;
        exp_t x;
        n        = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_dc    = 10'(dc);
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done         = 1'b1;
                last_acc_cyc = cyc;
                if (push) begin
                    x.code    = enc_code(10'(ed), ec == 0);
                    x.comp    = 2'(ec);
                    x.restart = er[0];
                    exp_q.push_back(x);
                end
                @(posedge clk);
                #1;
            end else begin
                n++;
                if (n > 200) begin
                    chk("accept_timeout", 32'(in_ready), 1);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mp[0] = 0; mp[1] = 0; mp[2] = 0;
        mli = 0; mslot = 0; mcnt = 0; mpend = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_enc_dc", 32'(enc_dc), 0);
        chk("rst_enc_lum", 32'(enc_is_luminance), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    task automatic model_step(input int dc, output int ed, output int ec, output int er);
        ec = mslot;
        ed = dc - mp[mslot];
        if (ed > 255)  ed = 255;
        if (ed < -255) ed = -255;
        er = mpend ? 1 : 0;
        mpend = 1'b0;
        mp[mslot] = dc;
        if (mslot == 0) begin
            if (mli == LUMA - 1) begin
                mli   = 0;
                mslot = 1;
            end else begin
                mli++;
            end
        end else if (mslot == 1) begin
            mslot = 2;
        end else begin
            mslot = 0;
            if (RST_EN && RI > 0) begin
                mcnt++;
                if (mcnt == RI) begin
                    mcnt = 0;
                    mp[0] = 0; mp[1] = 0; mp[2] = 0;
                    mpend = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int acc0, acc, seen, dc, ed, ec, er, r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_dc     = '0;
        out_ready = 1'b1;
        do_reset();

`ifdef DC_RESTART_EN
        send(50, 50, 0, 0, 1);
        send(20, 20, 1, 0, 1);
        send(30, 30, 2, 0, 1);
        send(50, 50, 0, 1, 1);
        drain();
`else
        lat_arm = 1'b1;
        send(10, 10, 0, 0, 1);
        acc0 = last_acc_cyc;
        send(12, 2, 0, 0, 1);
        send(12, 0, 0, 0, 1);
        send(5, -7, 0, 0, 1);
        send(-3, -3, 1, 0, 1);
        send(7, 7, 2, 0, 1);
        drain();
        chk("accept_to_out_valid", 32'(ov_cyc - acc0), 4);

        do_reset();
        send(0, 0, 0, 0, 1);
        send(300, 255, 0, 0, 1);
        send(300, 0, 0, 0, 1);
        send(-300, -255, 0, 0, 1);
        drain();

        do_reset();
        out_ready = 1'b0;
        send(1, 1, 0, 0, 1);
        send(2, 1, 0, 0, 1);
        send(3, 1, 0, 0, 1);
        send(4, 1, 0, 0, 1);
        in_valid = 1'b1;
        in_dc    = 10'sd9;
        exp_q.push_back('{code: enc_code(10'd9, 1'b0), comp: 2'd1, restart: 1'b0});
        acc = 0;
        repeat (8) begin
            @(negedge clk);
            if (in_ready) acc++;
        end
        chk("extra_accepts_when_full", 32'(acc), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_at_first_pop", 32'(in_ready), 0);
        chk("out_valid_when_full", 32'(out_valid), 1);
        @(negedge clk);
        chk("in_ready_after_first_pop", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        do_reset();
        send(5, 5, 0, 0, 0);
        send(6, 1, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("out_valid_after_mid_reset", 32'(seen), 0);
        chk("enc_dc_after_mid_reset", 32'(enc_dc), 0);
        @(posedge clk);
        #1;
        send(8, 8, 0, 0, 1);
        drain();
`endif

        do_reset();
        rand_rdy = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            r = int'($urandom_range(0, 9));
            if (r == 0)      dc = 511;
            else if (r == 1) dc = -512;
            else             dc = int'($urandom_range(0, 1023)) - 512;
            model_step(dc, ed, ec, er);
            send(dc, ed, ec, er, 1);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
